// File: rtl/a_loader_pkg.sv
// rtl/a_loader_pkg.sv - shared types and sizing helpers for the A-row loader
//
// Purpose: loader FSM state encoding, derived-constant helpers (elements per
// word, words per row, counter widths) and the configuration legality check
// used at elaboration time by the loader and its row assembler.
// Ports: none (package).

package a_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Elements carried by one input word.
  function automatic int calc_epw(input int in_w, input int bits_ab);
    return in_w / bits_ab;
  endfunction

  // Input words needed to fill one DIM-element row.
  function automatic int calc_wpr(input int dim, input int in_w, input int bits_ab);
    return dim / (in_w / bits_ab);
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Words must hold a whole number of elements, and a whole number of words
  // must make up a row, so no element ever straddles a word or row boundary.
  function automatic bit cfg_ok(input int dim, input int in_w, input int bits_ab);
    return (bits_ab > 0) && (in_w >= bits_ab) && ((in_w % bits_ab) == 0) &&
           ((dim % (in_w / bits_ab)) == 0);
  endfunction

endpackage

// File: rtl/row_assembler.sv
// rtl/row_assembler.sv - packs input words into one DIM-element row
//
// Purpose: holds the partially filled row and merges each accepted word into
// its slot range. The merged view (buffer plus the word on the bus) is
// presented combinationally so the loader can capture a finished row on the
// same edge that accepts its last word.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears buffer)
//   i_word            packed input word, element k at [k*BITS_AB +: BITS_AB]
//   i_word_idx        position of i_word within the row (0..WPR-1)
//   i_accept          word is being accepted this cycle
//   o_row             buffer merged with i_word at slot range of i_word_idx
//   o_row_complete    i_accept on the last word of a row

module row_assembler
  import a_loader_pkg::*;
#(
  parameter  int BITS_AB = 8,
  parameter  int DIM     = 8,
  parameter  int IN_W    = 64,
  localparam int EPW     = calc_epw(IN_W, BITS_AB),
  localparam int WPR     = calc_wpr(DIM, IN_W, BITS_AB),
  localparam int WW      = cnt_w(WPR)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_W-1:0]           i_word,
  input  logic [WW-1:0]             i_word_idx,
  input  logic                      i_accept,
  output logic signed [BITS_AB-1:0] o_row [DIM],
  output logic                      o_row_complete
);

  localparam logic [WW-1:0] LAST_WORD = WW'(WPR - 1);

  logic signed [BITS_AB-1:0] r_buf [DIM];
  logic signed [BITS_AB-1:0] w_row [DIM];

  // Slot s belongs to word s/EPW at element position s%EPW; element 0 of the
  // word lands in the lowest slot of its range.
  always_comb begin
    for (int s = 0; s < DIM; s++) begin
      if (i_word_idx == WW'(s / EPW)) begin
        w_row[s] = i_word[(s % EPW)*BITS_AB +: BITS_AB];
      end else begin
        w_row[s] = r_buf[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DIM; s++) begin
        r_buf[s] <= '0;
      end
    end else if (i_accept) begin
      for (int s = 0; s < DIM; s++) begin
        r_buf[s] <= w_row[s];
      end
    end
  end

  assign o_row          = w_row;
  assign o_row_complete = i_accept && (i_word_idx == LAST_WORD);

endmodule

// File: rtl/a_row_loader.sv
// rtl/a_row_loader.sv - stream-to-row feeder for the skewed A-matrix buffer
//
// Purpose: on start, accepts WPR*DIM packed words over a valid/ready stream,
// writes rows 0..DIM-1 into the A buffer, then holds the buffer shift enable
// for STREAM_CYC cycles and pulses done.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle load request, honoured only in IDLE
//   in_valid     input word valid
//   in_ready     loader accepts a word this cycle (registered, LOAD only)
//   in_data      packed input word, element k at [k*BITS_AB +: BITS_AB]
//   Ain          row data for the A buffer (held while WrEn=0)
//   Arow         row index for Ain (held while WrEn=0)
//   WrEn         one-cycle row write strobe
//   en           A buffer shift enable during the drain window
//   busy         loader is not idle
//   done         one-cycle completion pulse

module a_row_loader
  import a_loader_pkg::*;
#(
  parameter  int BITS_AB    = 8,
  parameter  int DIM        = 8,
  parameter  int IN_W       = 64,
  parameter  int STREAM_CYC = 3*DIM - 2,
  localparam int WPR        = calc_wpr(DIM, IN_W, BITS_AB),
  localparam int WW         = cnt_w(WPR),
  localparam int RW         = cnt_w(DIM),
  localparam int CW         = $clog2(STREAM_CYC + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  output logic signed [BITS_AB-1:0] Ain [DIM],
  output logic [RW-1:0]             Arow,
  output logic                      WrEn,
  output logic                      en,
  output logic                      busy,
  output logic                      done
);

  if (!cfg_ok(DIM, IN_W, BITS_AB)) begin : g_bad_cfg
    $error("a_row_loader: IN_W must be a multiple of BITS_AB and IN_W/BITS_AB must divide DIM");
  end

  localparam logic [WW-1:0] LAST_WORD = WW'(WPR - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(DIM - 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(STREAM_CYC);

  state_t                    r_state;
  logic [WW-1:0]             r_word_cnt;
  logic [RW-1:0]             r_row_cnt;
  logic [CW-1:0]             r_cyc_cnt;
  logic                      r_in_ready;
  logic                      r_wr_en;
  logic                      r_en;
  logic                      r_done;
  logic signed [BITS_AB-1:0] r_ain [DIM];
  logic [RW-1:0]             r_arow;

  logic                      w_accept;
  logic signed [BITS_AB-1:0] w_row [DIM];
  logic                      w_row_complete;

  // in_ready is a flop, so acceptance never loops back through in_valid.
  assign w_accept = in_valid && r_in_ready;

  row_assembler #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .IN_W    (IN_W)
  ) u_row_assembler (
    .clk            (clk),
    .rst            (rst),
    .i_word         (in_data),
    .i_word_idx     (r_word_cnt),
    .i_accept       (w_accept),
    .o_row          (w_row),
    .o_row_complete (w_row_complete)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_word_cnt <= '0;
      r_row_cnt  <= '0;
      r_cyc_cnt  <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_en       <= 1'b0;
      r_done     <= 1'b0;
      r_arow     <= '0;
      for (int k = 0; k < DIM; k++) begin
        r_ain[k] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_wr_en <= 1'b0;
          r_en    <= 1'b0;
          r_done  <= 1'b0;
          if (start) begin
            r_state    <= LOAD;
            r_in_ready <= 1'b1;
            r_word_cnt <= '0;
            r_row_cnt  <= '0;
            r_cyc_cnt  <= '0;
          end
        end

        LOAD: begin
          // Strobe drops unless the next row completes right behind it;
          // in_ready stays high so rows can arrive back to back.
          r_wr_en <= 1'b0;
          if (w_accept) begin
            r_word_cnt <= (r_word_cnt == LAST_WORD) ? '0 : r_word_cnt + 1'b1;
            if (w_row_complete) begin
              for (int k = 0; k < DIM; k++) begin
                r_ain[k] <= w_row[k];
              end
              r_arow  <= r_row_cnt;
              r_wr_en <= 1'b1;
              if (r_row_cnt == LAST_ROW) begin
                // The drain window opens on the same cycle as the last
                // row write, so en's first cycle overlaps that WrEn.
                r_row_cnt  <= '0;
                r_state    <= STREAM;
                r_in_ready <= 1'b0;
                r_en       <= 1'b1;
                r_cyc_cnt  <= CW'(1);
              end else begin
                r_row_cnt <= r_row_cnt + 1'b1;
              end
            end
          end
        end

        STREAM: begin
          // r_cyc_cnt numbers the en cycle currently in progress (1-based).
          r_wr_en <= 1'b0;
          if (r_cyc_cnt == LAST_CYC) begin
            r_en      <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
            r_cyc_cnt <= '0;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
          end
        end

        DONE: begin
          // start is deliberately not sampled here.
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign Ain      = r_ain;
  assign Arow     = r_arow;
  assign WrEn     = r_wr_en;
  assign en       = r_en;
  assign done     = r_done;
  assign busy     = (r_state != IDLE);

endmodule
